// File: rtl/axis_stream_arbiter.sv
// Round-robin burst arbiter that shares one downstream stream between K requesters.
// Each grant lasts a configurable number of beats, and its first beat is flagged on m_axis_tfirst.
module axis_stream_arbiter #(
  parameter int K = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic [K-1:0]   s_axis_tnext,
  input  logic [K*W-1:0] s_axis_tdata,
  input  logic [K-1:0]   s_axis_tfirst,
  input  logic [K-1:0]   s_axis_tvalid,
  input  logic           m_axis_tnext,
  output logic [W-1:0]   m_axis_tdata,
  output logic           m_axis_tfirst,
  output logic           m_axis_tvalid,
  input  logic [15:0]    cfg_burst_len,
  output logic [K-1:0]   grant,
  output logic           busy,
  output logic [15:0]    beats_left
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [K-1:0] ONE = K'(1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [K-1:0]   grant_nx;
  logic [15:0]    beats_nx;
  logic [IW-1:0]  rr;
  logic [IW-1:0]  rr_nx;
  logic           first_flag;
  logic           first_nx;
  logic [IW-1:0]  g;
  logic [IW-1:0]  win;
  logic           win_ok;
  logic           beat;
  int             idx;

  assign busy = (state == XFER);

  always_comb begin
    g = '0;
    for (int i = 0; i < K; i++)
      if (grant[i]) g = g | IW'(i);
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < K; i++)
      if (grant[i])
        m_axis_tdata = m_axis_tdata | s_axis_tdata[i*W +: W];
  end

  assign m_axis_tvalid = |(grant & s_axis_tvalid);
  assign s_axis_tnext  = grant & {K{m_axis_tnext}};
  assign m_axis_tfirst = busy & s_axis_tvalid[g]
                       & (first_flag | s_axis_tfirst[g]);
  assign beat = m_axis_tvalid & m_axis_tnext;

  // Scan far-to-near so the requester nearest rr+1 is the last to claim win.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int off = K; off >= 1; off--) begin
      idx = (int'(rr) + off) % K;
      if (s_axis_tvalid[IW'(idx)]) begin
        win    = IW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    beats_nx = beats_left;
    rr_nx    = rr;
    first_nx = first_flag;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          state_nx = XFER;
          grant_nx = ONE << win;
          beats_nx = (cfg_burst_len == 16'd0) ? 16'd1 : cfg_burst_len;
          first_nx = 1'b1;
        end
      end
      XFER: begin
        if (beat) begin
          first_nx = 1'b0;
          if (beats_left == 16'd1) begin
            state_nx = IDLE;
            grant_nx = '0;
            beats_nx = '0;
            rr_nx    = g;
          end else begin
            beats_nx = beats_left - 16'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      beats_left <= '0;
      rr         <= IW'(K - 1);
      first_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      beats_left <= beats_nx;
      rr         <= rr_nx;
      first_flag <= first_nx;
    end
  end

endmodule

// File: doc/axis_stream_arbiter.md
Name: axis_stream_arbiter

Overview:
- Shares one downstream tnext/tfirst/tvalid stream consumer (typically a width converter instance) between K upstream requesters.
- Grants are round-robin, one burst at a time; each burst is cfg_burst_len beats long.
- Marks the first beat of every granted burst with m_axis_tfirst, so downstream converters realign on each segment.
- Sits between the per-channel sources and the shared converter.

Parameters:
- K, 4: number of requester streams (2..16).
- W, 8: data width of every stream, in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tnext  output  K  per-requester consume strobe.
- s_axis_tdata  input  K*W  requester data; requester i occupies bits [i*W +: W].
- s_axis_tfirst  input  K  per-requester frame-start marker.
- s_axis_tvalid  input  K  per-requester valid.
- m_axis_tnext  input  1  downstream consume strobe.
- m_axis_tdata  output  W  muxed data.
- m_axis_tfirst  output  1  first beat of burst, or a source frame start.
- m_axis_tvalid  output  1  muxed valid.
- cfg_burst_len  input  16  beats per grant; sampled at grant time; 0 is treated as 1.
- grant  output  K  one-hot current grant; all zeros when idle.
- busy  output  1  high while in XFER.
- beats_left  output  16  remaining beats in the current burst.

Behaviour:
- Beat rule: a beat transfers in any cycle where m_axis_tvalid and m_axis_tnext are both high.
- Reset (rst low, asynchronous):
  - state=IDLE, grant=0, busy=0, beats_left=0, rr pointer=K-1 (requester 0 has first priority), first_flag=0.
  - Combinational outputs then read: m_axis_tvalid=0, m_axis_tfirst=0, s_axis_tnext=0. m_axis_tdata is don't-care, but drives 0 when grant=0.
- Reset mid-burst: the burst is abandoned immediately. The requester's remaining beats stay at its source, and no beat is lost or duplicated.
- Datapath: purely combinational mux, no added latency.
  - m_axis_tdata = s_axis_tdata of the granted requester.
  - m_axis_tvalid = |(grant & s_axis_tvalid).
  - s_axis_tnext[i] = grant[i] & m_axis_tnext.
  - Ungranted requesters always see tnext=0.
- m_axis_tfirst = busy & s_axis_tvalid[g] & (first_flag | s_axis_tfirst[g]), where g is the granted index.
- IDLE state:
  - grant=0.
  - If |s_axis_tvalid, the winner is the first requester with tvalid high, searching from rr pointer+1 upward with wrap modulo K.
  - Next edge: state=XFER, grant=onehot(winner), beats_left=max(cfg_burst_len,1), first_flag=1, busy=1.
  - Latency: grant appears the cycle after the request is first seen.
- XFER state:
  - On each beat: beats_left decrements and first_flag clears.
  - On the beat where beats_left==1: rr pointer=g, then next edge state=IDLE, grant=0, busy=0, beats_left=0.
  - This leaves a mandatory one-cycle bubble between bursts.
- Granted source drops tvalid mid-burst: the grant is held indefinitely. There is no timeout or preemption, and beats_left is unchanged.
- cfg_burst_len changes mid-burst: no effect until the next grant.
- A single active requester receives back-to-back bursts, with one idle cycle between them.
- All requesters valid: grant order is 0,1,...,K-1,0,...; this is starvation-free.
- Source tfirst mid-burst: forwarded on m_axis_tfirst; it does not end the burst.
- Beat counting: beats_left is 16-bit and never wraps below 0. A beat with beats_left==0 cannot occur, because tvalid is gated by busy.

Test Plan:
- Reset with all s_axis_tvalid high, then release rst:
  - grant=0001 one cycle after release.
  - m_axis_tfirst=1 on the first beat only.
  - With cfg_burst_len=3 and m_axis_tnext=1: exactly 3 beats from requester 0, then one idle cycle.
- All four requesters valid, cfg_burst_len=2, m_axis_tnext=1 continuously, 20 cycles:
  - grant sequence is 0001,0010,0100,1000,0001.
  - Each grant carries 2 beats.
  - Each burst is followed by one cycle with grant=0.
- Only requester 2 valid, cfg_burst_len=0:
  - Treated as 1.
  - Alternating single-beat bursts: grant=0100 one cycle, 0000 the next.
- Backpressure: m_axis_tnext toggles 1,0,1,0 during a 4-beat burst:
  - beats_left goes 4,3,3,2,2,1,1,0 across 8 cycles.
  - s_axis_tnext[g] mirrors m_axis_tnext exactly.
- Granted source drops tvalid for 5 cycles at beats_left=2:
  - grant is held and beats_left stays 2.
  - Other requesters see tnext=0.
  - The burst resumes and completes normally.
- Assert rst for 1 cycle in the middle of a 4-beat burst after beat 2:
  - All outputs return to reset values asynchronously.
  - After release, requester 0 (if valid) is granted.
  - The scoreboard shows no lost or duplicated data words.
